// File: rtl/rx_port_arbiter_if.sv
// Bus bundle for rx_port_arbiter: PORTS receive streams in, one muxed stream
// out, plus the in-order source-port FIFO read side.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised it holds its payload
// until that edge. Ready may depend on valid, but valid never depends on ready.
interface rx_port_arbiter_if #(
    parameter int PORTS           = 4,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PORT_WIDTH      = (PORTS > 1 ? $clog2(PORTS) : 1)
);
    logic [PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata;
    logic [PORTS*AXIS_KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [PORTS-1:0]                 s_axis_tvalid;
    logic [PORTS-1:0]                 s_axis_tready;
    logic [PORTS-1:0]                 s_axis_tlast;
    logic [AXIS_DATA_WIDTH-1:0]       m_axis_tdata;
    logic [AXIS_KEEP_WIDTH-1:0]       m_axis_tkeep;
    logic                             m_axis_tvalid;
    logic                             m_axis_tready;
    logic                             m_axis_tlast;
    logic [PORT_WIDTH-1:0]            m_axis_tid;
    logic [PORT_WIDTH-1:0]            m_port_id;
    logic                             m_port_id_valid;
    logic                             m_port_id_ready;
    logic                             busy;

    // Arbiter side.
    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  m_axis_tready, m_port_id_ready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
        output m_port_id, m_port_id_valid, busy
    );

    // Environment side: RX ports, parser wrapper and descriptor pairing logic.
    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output m_axis_tready, m_port_id_ready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
        input  m_port_id, m_port_id_valid, busy
    );
endinterface

// File: rtl/rx_port_arbiter.sv
// Packet-granular round-robin arbiter: locks one RX port from first beat to
// tlast and logs each granted source port in an in-order FIFO.
module rx_port_arbiter #(
    parameter int PORTS           = 4,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PORT_WIDTH      = (PORTS > 1 ? $clog2(PORTS) : 1),
    parameter int ID_FIFO_DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    rx_port_arbiter_if.master  bus
);
    localparam int AW = $clog2(ID_FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, PASS} state_t;

    state_t                state_q, state_d;
    logic [PORT_WIDTH-1:0] grant_q, grant_d;
    logic [PORT_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [PORT_WIDTH-1:0] pick;
    logic                  pick_found;
    logic                  m_valid;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;

    logic [PORT_WIDTH-1:0] fifo_mem_q [ID_FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;

    assign fifo_full  = (count_q == CW'(ID_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus.m_port_id_ready;

    // Search starts one past the last completed grant and wraps.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(last_grant_q) + 1 + k;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!pick_found && bus.s_axis_tvalid[idx]) begin
                pick_found = 1'b1;
                pick       = PORT_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_WIDTH'(PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !fifo_full) begin
                    state_d = PASS;
                    grant_d = pick;
                    push    = 1'b1;
                end
            end
            PASS: begin
                if (m_valid && bus.m_axis_tready && bus.s_axis_tlast[grant_q]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_tready = '0;
        m_valid           = 1'b0;
        if (state_q == PASS) begin
            bus.s_axis_tready[grant_q] = bus.m_axis_tready;
            m_valid                    = bus.s_axis_tvalid[grant_q];
        end
    end

    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = bus.s_axis_tdata[grant_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign bus.m_axis_tkeep  = bus.s_axis_tkeep[grant_q*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    assign bus.m_axis_tlast  = bus.s_axis_tlast[grant_q];
    assign bus.m_axis_tid    = grant_q;
    assign bus.busy          = (state_q == PASS);

    // Source-port FIFO; entry is written at grant time, before any beat moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= pick;
    end

    assign bus.m_port_id       = fifo_mem_q[rd_ptr_q];
    assign bus.m_port_id_valid = !fifo_empty;
endmodule
